div_share_arbiter: RTL
======================

Name: div_share_arbiter

Overview:
- Shares one pipelined Divider_Modulo between NUM_REQ independent requesters.
- Round-robin arbitration issues at most one operation per cycle into the divider.
- A fixed-depth requester-tag pipe tracks every operation in flight and steers each div_result back to the requester that issued it.
- Sits between requester blocks and the divider instance at the arithmetic-unit top level.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- DIV_LATENCY, 32: cycles from div_valid_in to the matching div_valid_out; must equal the divider build.
- ID_W, 2: requester index width, equal to clog2(NUM_REQ).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset. The divider's reset is driven by the inverse of this signal at the top level.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- req_mode  in  NUM_REQ  per-requester mode: 0 = quotient, 1 = remainder.
- req_divisor  in  NUM_REQ*16  packed divisors; requester i occupies bits [16i+15:16i].
- req_dividend  in  NUM_REQ*32  packed dividends; requester i occupies bits [32i+31:32i].
- div_valid_in  out  1  to divider.
- div_mode  out  1  to divider.
- div_divisor  out  16  to divider.
- div_dividend  out  32  to divider.
- div_valid_out  in  1  from divider.
- div_result  in  32  from divider.
- rsp_valid  out  NUM_REQ  one-hot response strobe, one cycle wide.
- rsp_result  out  32  response data, valid when any rsp_valid bit is high.
- busy  out  1  any operation in the issue register, tag pipe or response register.
- err_sync  out  1  sticky tag/valid mismatch flag.

Behaviour:
- Reset state: all outputs 0, tag pipe cleared, round-robin pointer at 0, so requester 0 has highest priority. Reset asserted mid-operation discards all in-flight operations; no rsp_valid is produced for them.
- Arbitration (combinational):
  - Search starts at the index one above the last granted requester, wrapping modulo NUM_REQ.
  - req_ready is one-hot on the first requester with req_valid high; all-zero when no requester is valid.
  - The divider accepts every cycle, so a grant is issued every cycle a request is pending.
  - The pointer updates only on a transfer.
  - A requester may hold req_valid high continuously. Under contention every valid requester is granted within NUM_REQ cycles.
- Issue register, updated on a transfer at cycle T:
  - At T+1: div_valid_in=1 and div_mode/div_divisor/div_dividend carry the granted requester's fields.
  - Otherwise div_valid_in=0 and the data fields hold their last value.
- Tag pipe:
  - DIV_LATENCY stages of {valid, ID_W id}, shifted every cycle.
  - Stage 0 is loaded with {div_valid_in, issued id} at the same edge as the divider input.
  - The last stage is aligned with div_valid_out.
- Response:
  - Registered one cycle after div_valid_out.
  - rsp_valid[id]=1 and rsp_result=div_result.
  - Total request-to-response latency is DIV_LATENCY+2 cycles (transfer at T, response at T+2+DIV_LATENCY).
  - Responses return in issue order. There is no response backpressure; requesters must sink rsp_valid.
- err_sync is set when the last tag stage's valid bit differs from div_valid_out.
  - On that event the response is suppressed for that cycle.
  - err_sync clears only on reset.
- busy = issue valid OR any tag stage valid OR any rsp_valid bit high.
- Simultaneous transfer and response in the same cycle are independent and both occur.
- Pointer wrap: after granting NUM_REQ-1, requester 0 has highest priority.

Optional Feature:
- Macro: DIV_ZERO_BYPASS_EN.
- Defined:
  - A granted request with divisor==0 is not sent to the divider; div_valid_in stays 0 in that slot.
  - Its tag enters the pipe with a bypass bit and a 32-bit local result: 32'hFFFF_FFFF for mode 0, the dividend for mode 1.
  - At the last stage the local result is returned in place of div_result.
  - Latency and ordering are unchanged.
  - err_sync ignores bypass slots, where div_valid_out is expected to be 0.
- Undefined: zero divisors are issued to the divider unchanged, and the result is whatever the divider produces.

Test Plan:
- Single op:
  - Stimulus: requester 1 issues mode 0, dividend 537133248, divisor 25347.
  - Required: rsp_valid=4'b0010 and rsp_result=21191 exactly DIV_LATENCY+2 cycles after the transfer; busy falls the cycle after.
- Contention:
  - Stimulus: requesters 0..3 hold req_valid for 8 cycles.
  - Required: grant order 0,1,2,3,0,1,2,3; each response returns to the correct index in the same order.
- Back-to-back ops:
  - Stimulus: requester 2 issues mode 1 (690275523/25443), then requester 0 issues mode 0 (537133248/25347) on the next cycle.
  - Required: rsp_valid=4'b0100 with result 6933, then 4'b0001 with result 21191 on the next cycle.
- Reset mid-flight:
  - Stimulus: issue 3 ops, assert reset for 2 cycles at DIV_LATENCY/2.
  - Required: no rsp_valid, busy=0, next grant goes to requester 0.
- Sync error:
  - Stimulus: force div_valid_out=1 with the tag pipe empty.
  - Required: err_sync rises the next cycle and stays high, no rsp_valid; cleared only by reset.
- Zero divisor, DIV_ZERO_BYPASS_EN defined:
  - Stimulus: requester 3 issues mode 1, dividend 1234, divisor 0.
  - Required: div_valid_in stays 0 for that slot; rsp_valid=4'b1000 and rsp_result=1234 after DIV_LATENCY+2 cycles.

Source files
------------

// File: rtl/div_share_arbiter.sv
// Round-robin sharing of one pipelined Divider_Modulo between NUM_REQ requesters.
// Build option DIV_ZERO_BYPASS_EN answers zero-divisor requests locally through the tag pipe.
module div_share_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DIV_LATENCY = 32,
    parameter int ID_W        = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_mode,
    input  logic [NUM_REQ*16-1:0] req_divisor,
    input  logic [NUM_REQ*32-1:0] req_dividend,
    output logic                  div_valid_in,
    output logic                  div_mode,
    output logic [15:0]           div_divisor,
    output logic [31:0]           div_dividend,
    input  logic                  div_valid_out,
    input  logic [31:0]           div_result,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [31:0]           rsp_result,
    output logic                  busy,
    output logic                  err_sync
);

    // Handshake: requester i transfers on a rising edge where req_valid[i] && req_ready[i];
    // req_ready is a one-hot grant and never depends on anything the requester does later.
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] grant_id;
    logic [ID_W:0]   arb_idx;
    logic            xfer;
    logic            sel_mode;
    logic [15:0]     sel_divisor;
    logic [31:0]     sel_dividend;

    always_comb begin
        req_ready = '0;
        grant_id  = '0;
        xfer      = 1'b0;
        arb_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            arb_idx = {1'b0, ptr} + (ID_W+1)'(k);
            if (arb_idx >= (ID_W+1)'(NUM_REQ)) begin
                arb_idx = arb_idx - (ID_W+1)'(NUM_REQ);
            end
            if (!xfer && req_valid[arb_idx[ID_W-1:0]]) begin
                xfer                          = 1'b1;
                req_ready[arb_idx[ID_W-1:0]]  = 1'b1;
                grant_id                      = arb_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        sel_mode     = 1'b0;
        sel_divisor  = '0;
        sel_dividend = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                sel_mode     = req_mode[i];
                sel_divisor  = req_divisor[16*i +: 16];
                sel_dividend = req_dividend[32*i +: 32];
            end
        end
    end

    logic            zero_byp;
    logic            iss_byp;
    logic            last_byp;
    logic [31:0]     last_res;
    logic [ID_W-1:0] iss_id;

    // ptr holds the highest-priority index: one above the last granted requester.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr          <= '0;
            iss_id       <= '0;
            div_valid_in <= 1'b0;
            div_mode     <= 1'b0;
            div_divisor  <= '0;
            div_dividend <= '0;
        end else begin
            div_valid_in <= xfer && !zero_byp;
            if (xfer) begin
                ptr    <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
                iss_id <= grant_id;
            end
            if (xfer && !zero_byp) begin
                div_mode     <= sel_mode;
                div_divisor  <= sel_divisor;
                div_dividend <= sel_dividend;
            end
        end
    end

`ifdef DIV_ZERO_BYPASS_EN
    logic [31:0]                  iss_res;
    logic [DIV_LATENCY-1:0]       tag_b;
    logic [DIV_LATENCY-1:0][31:0] tag_r;

    assign zero_byp = xfer && (sel_divisor == 16'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iss_byp <= 1'b0;
            iss_res <= '0;
            tag_b   <= '0;
            tag_r   <= '0;
        end else begin
            iss_byp <= zero_byp;
            if (zero_byp) begin
                iss_res <= sel_mode ? sel_dividend : 32'hFFFF_FFFF;
            end
            tag_b <= {tag_b[DIV_LATENCY-2:0], iss_byp};
            tag_r <= {tag_r[DIV_LATENCY-2:0], iss_res};
        end
    end

    assign last_byp = tag_b[DIV_LATENCY-1];
    assign last_res = tag_r[DIV_LATENCY-1];
`else
    assign zero_byp = 1'b0;
    assign iss_byp  = 1'b0;
    assign last_byp = 1'b0;
    assign last_res = '0;
`endif

    // Stage 0 loads at the same edge the divider samples div_valid_in, so the last
    // stage lines up with div_valid_out.
    logic [DIV_LATENCY-1:0]           tag_v;
    logic [DIV_LATENCY-1:0][ID_W-1:0] tag_id;
    logic                             mismatch;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v  <= {tag_v[DIV_LATENCY-2:0], div_valid_in | iss_byp};
            tag_id <= {tag_id[DIV_LATENCY-2:0], iss_id};
        end
    end

    // Bypass slots never reach the divider, so they are excluded from the sync check.
    assign mismatch = !last_byp && (tag_v[DIV_LATENCY-1] != div_valid_out);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid  <= '0;
            rsp_result <= '0;
            err_sync   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (mismatch) begin
                err_sync <= 1'b1;
            end
            if (tag_v[DIV_LATENCY-1] && !mismatch) begin
                rsp_valid  <= NUM_REQ'(1) << tag_id[DIV_LATENCY-1];
                rsp_result <= last_byp ? last_res : div_result;
            end
        end
    end

    assign busy = div_valid_in | iss_byp | (|tag_v) | (|rsp_valid);

endmodule
